// File: rtl/block_instr_fetch.sv
// rtl/block_instr_fetch.sv - Instruction fetch sequencer with stall skid register.
// Optional NOP skipping under BLOCK_INSTR_FETCH_NOP_SKIP_EN (NOP opcode in `BLOCK_INSTR_NOP).

`ifndef BLOCK_INSTR_NOP
`define BLOCK_INSTR_NOP 5'h13
`endif

module block_instr_fetch #(
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sample_tick,
  input  logic [ADDR_WIDTH:0]   n_instrs,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  output logic                  mem_ren,
  input  logic [31:0]           mem_rdata,
  input  logic                  stall,
  output logic [31:0]           instr,
  output logic                  instr_valid,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  busy,
  output logic                  done,
  output logic                  overrun
);

  localparam logic [ADDR_WIDTH:0] DEPTH_N = (ADDR_WIDTH+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [ADDR_WIDTH:0]   last_addr;
  logic                  rd_pend;
  logic [ADDR_WIDTH-1:0] pend_addr;
  logic                  skid_valid;
  logic [31:0]           skid_data;
  logic [ADDR_WIDTH-1:0] skid_pc;
  logic                  zero_done;
  logic                  overrun_r;

  logic                  word_is_nop;
  logic                  fresh_valid;
  logic                  accept;
  logic                  nop_last;
  logic                  pass_done;
  logic                  start;
  logic [ADDR_WIDTH:0]   n_clamped;

`ifdef BLOCK_INSTR_FETCH_NOP_SKIP_EN
  assign word_is_nop = (mem_rdata[4:0] == `BLOCK_INSTR_NOP);
`else
  assign word_is_nop = 1'b0;
`endif

  // Returning read data is presented directly; the skid only holds a word that arrived under stall.
  assign fresh_valid = rd_pend && !word_is_nop;
  assign instr_valid = skid_valid || fresh_valid;
  assign instr       = skid_valid ? skid_data : (fresh_valid ? mem_rdata : 32'd0);
  assign pc          = skid_valid ? skid_pc : (fresh_valid ? pend_addr : '0);
  assign accept      = instr_valid && !stall;
  assign nop_last    = rd_pend && word_is_nop && ({1'b0, pend_addr} == last_addr);
  assign pass_done   = (state == DRAIN) && ((accept && ({1'b0, pc} == last_addr)) || nop_last);

  assign busy      = (state != IDLE);
  assign mem_ren   = (state == FETCH) && !(instr_valid && stall);
  assign mem_raddr = mem_ren ? rd_addr : '0;
  assign done      = pass_done || zero_done;
  assign overrun   = overrun_r;

  assign n_clamped = (n_instrs > DEPTH_N) ? DEPTH_N : n_instrs;
  assign start     = sample_tick && (n_instrs != '0) && ((state == IDLE) || pass_done);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (start) state_next = FETCH;
      FETCH: if (mem_ren && ({1'b0, rd_addr} == last_addr)) state_next = DRAIN;
      DRAIN: if (pass_done) state_next = start ? FETCH : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_addr    <= '0;
      last_addr  <= '0;
      rd_pend    <= 1'b0;
      pend_addr  <= '0;
      skid_valid <= 1'b0;
      skid_data  <= 32'd0;
      skid_pc    <= '0;
      zero_done  <= 1'b0;
      overrun_r  <= 1'b0;
    end else begin
      rd_pend   <= mem_ren;
      pend_addr <= rd_addr;
      zero_done <= sample_tick && (n_instrs == '0) && ((state == IDLE) || pass_done);
      overrun_r <= sample_tick && busy && !pass_done;

      if (start) begin
        rd_addr   <= '0;
        last_addr <= n_clamped - 1'b1;
      end else if (mem_ren && ({1'b0, rd_addr} != last_addr)) begin
        rd_addr <= rd_addr + 1'b1;
      end

      if (skid_valid && !stall) begin
        skid_valid <= 1'b0;
      end else if (fresh_valid && stall) begin
        skid_valid <= 1'b1;
        skid_data  <= mem_rdata;
        skid_pc    <= pend_addr;
      end
    end
  end

endmodule

// File: tb/tb_block_instr_fetch.sv
// tb/tb_block_instr_fetch.sv - Directed self-checking bench for block_instr_fetch.
// Honours BLOCK_INSTR_FETCH_NOP_SKIP_EN for the NOP scenario.

`ifndef BLOCK_INSTR_NOP
`define BLOCK_INSTR_NOP 5'h13
`endif

module tb_block_instr_fetch;

`ifdef BLOCK_INSTR_FETCH_NOP_SKIP_EN
  localparam bit NOP_EN = 1'b1;
`else
  localparam bit NOP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sample_tick = 1'b0;
  logic [8:0]  n_instrs = '0;
  logic [7:0]  mem_raddr;
  logic        mem_ren;
  logic [31:0] mem_rdata = 32'd0;
  logic        stall = 1'b0;
  logic [31:0] instr;
  logic        instr_valid;
  logic [7:0]  pc;
  logic        busy;
  logic        done;
  logic        overrun;

  block_instr_fetch dut (
    .clk(clk), .reset(reset), .sample_tick(sample_tick), .n_instrs(n_instrs),
    .mem_raddr(mem_raddr), .mem_ren(mem_ren), .mem_rdata(mem_rdata), .stall(stall),
    .instr(instr), .instr_valid(instr_valid), .pc(pc), .busy(busy), .done(done),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:255];
  always @(posedge clk) mem_rdata <= mem_ren ? mem[mem_raddr] : 32'hBAD0BAD0;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit is_nop(input logic [31:0] w);
    return NOP_EN && (w[4:0] == `BLOCK_INSTR_NOP);
  endfunction

  bit          tick_v  [0:299];
  bit          stall_v [0:299];
  bit          busy_at [0:299];
  bit          valid_at[0:299];
  logic [7:0]  pc_at   [0:299];
  logic [31:0] instr_at[0:299];
  int acc_cnt, ren_cnt, ren_first, first_valid, held1, done_cnt, done_first, done_last;
  int ovr_cnt, ovr_cycle, busy_cnt, max_addr, exp_idx;

  task automatic fill_mem(input bit with_nops);
    for (int i = 0; i < 256; i++) mem[i] = 32'hC000_0007 | (i << 8);
    if (with_nops) begin
      mem[1] = {27'h5EAD001, `BLOCK_INSTR_NOP};
      mem[3] = {27'h5EAD003, `BLOCK_INSTR_NOP};
    end
  endtask

  task automatic run_vec(input int ncyc, input int n);
    acc_cnt = 0; ren_cnt = 0; ren_first = -1; first_valid = -1; held1 = 0;
    done_cnt = 0; done_first = -1; done_last = -1; ovr_cnt = 0; ovr_cycle = -1;
    busy_cnt = 0; max_addr = 0; exp_idx = 0;
    n_instrs = 9'(n);
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk); #1;
      sample_tick = tick_v[c];
      stall = stall_v[c];
      @(negedge clk);
      busy_at[c] = busy; valid_at[c] = instr_valid; pc_at[c] = pc; instr_at[c] = instr;
      if (busy) busy_cnt++;
      if (mem_ren) begin
        ren_cnt++;
        if (ren_first < 0) ren_first = c;
        if (int'(mem_raddr) > max_addr) max_addr = int'(mem_raddr);
      end
      if (instr_valid && first_valid < 0) first_valid = c;
      if (instr_valid && pc == 8'd1) held1++;
      if (instr_valid && !stall) begin
        acc_cnt++;
        while (exp_idx < 255 && is_nop(mem[exp_idx])) exp_idx++;
        check("accepted_instr", instr, mem[exp_idx]);
        check("accepted_pc", 32'(pc), 32'(exp_idx));
        exp_idx++;
      end
      if (done) begin
        done_cnt++;
        if (done_first < 0) done_first = c;
        done_last = c;
        exp_idx = 0;
      end
      if (overrun) begin ovr_cnt++; ovr_cycle = c; end
    end
    @(posedge clk); #1;
    sample_tick = 1'b0; stall = 1'b0;
    for (int c = 0; c < 300; c++) begin tick_v[c] = 1'b0; stall_v[c] = 1'b0; end
  endtask

  initial begin
    for (int c = 0; c < 300; c++) begin tick_v[c] = 1'b0; stall_v[c] = 1'b0; end
    fill_mem(1'b0);
    #2;
    check("reset_ctrl", 32'({busy, instr_valid, mem_ren, done, overrun}), 32'd0);
    check("reset_instr_pc", instr | 32'({pc, mem_raddr}), 32'd0);
    #20;
    @(negedge clk); reset = 1'b0;

    // nominal 4-word pass; mem[1], mem[3] carry the NOP opcode
    fill_mem(1'b1);
    tick_v[0] = 1'b1;
    run_vec(8, 4);
    check("nom_busy_c0", 32'(busy_at[0]), 32'd0);
    check("nom_busy_c1", 32'(busy_at[1]), 32'd1);
    check("nom_ren_first", 32'(ren_first), 32'd1);
    check("nom_first_valid", 32'(first_valid), 32'd2);
    check("nom_instr_c2", instr_at[2], mem[0]);
    check("nom_accepted", 32'(acc_cnt), NOP_EN ? 32'd2 : 32'd4);
    check("nom_reads", 32'(ren_cnt), 32'd4);
    check("nom_done_cycle", 32'(done_first), 32'd5);
    check("nom_done_cnt", 32'(done_cnt), 32'd1);
    check("nom_busy_c6", 32'(busy_at[6]), 32'd0);
    check("nom_valid_c6", 32'(valid_at[6]), 32'd0);

    // stall for 3 cycles while B is presented
    fill_mem(1'b0);
    tick_v[0] = 1'b1;
    stall_v[3] = 1'b1; stall_v[4] = 1'b1; stall_v[5] = 1'b1;
    run_vec(11, 4);
    check("stall_b_held", 32'(held1), 32'd4);
    check("stall_accepted", 32'(acc_cnt), 32'd4);
    check("stall_reads", 32'(ren_cnt), 32'd4);
    check("stall_done_cycle", 32'(done_first), 32'd8);
    check("stall_instr_c7", instr_at[7], mem[2]);

    // zero-length pass
    tick_v[0] = 1'b1;
    run_vec(5, 0);
    check("zero_done_cycle", 32'(done_first), 32'd1);
    check("zero_done_cnt", 32'(done_cnt), 32'd1);
    check("zero_reads", 32'(ren_cnt), 32'd0);
    check("zero_busy", 32'(busy_cnt), 32'd0);

    // second tick two cycles into a 6-word pass
    tick_v[0] = 1'b1; tick_v[2] = 1'b1;
    run_vec(11, 6);
    check("ovr_cnt", 32'(ovr_cnt), 32'd1);
    check("ovr_cycle", 32'(ovr_cycle), 32'd3);
    check("ovr_reads", 32'(ren_cnt), 32'd6);
    check("ovr_accepted", 32'(acc_cnt), 32'd6);
    check("ovr_done_cnt", 32'(done_cnt), 32'd1);
    check("ovr_done_cycle", 32'(done_first), 32'd7);

    // tick coincident with done starts a back-to-back pass
    tick_v[0] = 1'b1; tick_v[5] = 1'b1;
    run_vec(14, 4);
    check("b2b_done_cnt", 32'(done_cnt), 32'd2);
    check("b2b_done_last", 32'(done_last), 32'd10);
    check("b2b_busy_c6", 32'(busy_at[6]), 32'd1);
    check("b2b_valid_c6", 32'(valid_at[6]), 32'd0);
    check("b2b_instr_c7", instr_at[7], mem[0]);
    check("b2b_pc_c7", 32'(pc_at[7]), 32'd0);
    check("b2b_overrun", 32'(ovr_cnt), 32'd0);
    check("b2b_accepted", 32'(acc_cnt), 32'd8);

    // n_instrs above DEPTH clamps to 256 reads, top address 255
    tick_v[0] = 1'b1;
    run_vec(262, 300);
    check("clamp_reads", 32'(ren_cnt), 32'd256);
    check("clamp_max_addr", 32'(max_addr), 32'd255);
    check("clamp_done_cycle", 32'(done_first), 32'd257);
    check("clamp_accepted", 32'(acc_cnt), 32'd256);

    // reset mid-pass
    tick_v[0] = 1'b1;
    run_vec(3, 6);
    @(negedge clk);
    check("mid_valid_before_rst", 32'(instr_valid), 32'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_ctrl", 32'({busy, instr_valid, mem_ren, done, overrun}), 32'd0);
    check("mid_rst_instr_pc", instr | 32'({pc, mem_raddr}), 32'd0);
    @(negedge clk); reset = 1'b0;
    run_vec(8, 6);
    check("post_rst_done", 32'(done_cnt), 32'd0);
    check("post_rst_reads", 32'(ren_cnt), 32'd0);
    check("post_rst_busy", 32'(busy_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
